// File: rtl/time_set_ctrl.sv
// rtl/time_set_ctrl.sv - clock time-of-day counter with set modes and field blink mask
// Counts h:m:s on sec_en in run mode; set modes freeze time and step one field per button press.
module time_set_ctrl #(
  parameter int HOUR_MAX = 23
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] mode,
  input  logic       sec_en,
  input  logic       half_en,
  input  logic       inc_btn,
  output logic [4:0] hour,
  output logic [5:0] minute,
  output logic [5:0] second,
  output logic [2:0] blink_mask,
  output logic       setting
);

  typedef enum logic [1:0] {
    MODE_RUN  = 2'b00,
    MODE_HOUR = 2'b01,
    MODE_MIN  = 2'b10,
    MODE_SEC  = 2'b11
  } mode_e;

  localparam logic [4:0] HOUR_TOP = 5'(HOUR_MAX);

  mode_e       mode_cur;
  mode_e       mode_q;
  logic        inc_q;
  logic        inc_rise;
  logic        blink_phase;
  logic        phase_n;
  logic [2:0]  mask_n;
  logic [4:0]  hour_n;
  logic [5:0]  minute_n;
  logic [5:0]  second_n;
  logic [4:0]  hour_inc;
  logic [5:0]  minute_inc;
  logic [5:0]  second_inc;
  logic        hour_wrap;
  logic        minute_wrap;
  logic        second_wrap;

  assign mode_cur = mode_e'(mode);
  assign inc_rise = inc_btn & ~inc_q;
  assign setting  = (mode != 2'b00);

  // ">=" also catches out-of-range register contents so they reload 0
  assign hour_wrap   = (hour >= HOUR_TOP);
  assign minute_wrap = (minute >= 6'd59);
  assign second_wrap = (second >= 6'd59);
  assign hour_inc    = hour_wrap   ? 5'd0 : hour + 5'd1;
  assign minute_inc  = minute_wrap ? 6'd0 : minute + 6'd1;
  assign second_inc  = second_wrap ? 6'd0 : second + 6'd1;

  always_comb begin
    hour_n   = hour;
    minute_n = minute;
    second_n = second;
    case (mode_cur)
      MODE_RUN: begin
        if (sec_en) begin
          second_n = second_inc;
          if (second_wrap) begin
            minute_n = minute_inc;
            if (minute_wrap) hour_n = hour_inc;
          end
        end
      end
      MODE_HOUR: if (inc_rise) hour_n   = hour_inc;
      MODE_MIN:  if (inc_rise) minute_n = minute_inc;
      MODE_SEC:  if (inc_rise) second_n = second_inc;
      default: ;
    endcase
  end

  // Any mode change or edit keeps the field visible so the user sees the result
  always_comb begin
    phase_n = blink_phase;
    if ((mode_cur != mode_q) || inc_rise) phase_n = 1'b1;
    else if (half_en)                     phase_n = ~blink_phase;
    mask_n = 3'b000;
    case (mode_cur)
      MODE_HOUR: mask_n[2] = ~phase_n;
      MODE_MIN:  mask_n[1] = ~phase_n;
      MODE_SEC:  mask_n[0] = ~phase_n;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hour        <= 5'd0;
      minute      <= 6'd0;
      second      <= 6'd0;
      blink_mask  <= 3'b000;
      blink_phase <= 1'b1;
      inc_q       <= 1'b0;
      mode_q      <= MODE_RUN;
    end else begin
      hour        <= hour_n;
      minute      <= minute_n;
      second      <= second_n;
      blink_mask  <= mask_n;
      blink_phase <= phase_n;
      inc_q       <= inc_btn;
      mode_q      <= mode_cur;
    end
  end

endmodule

// File: tb/tb_time_set_ctrl.sv
// tb/tb_time_set_ctrl.sv - self-checking bench for time_set_ctrl
// Vector table plus hand sequences; expectations go through a one-deep scoreboard queue.
module tb_time_set_ctrl;

  localparam int HM = 23;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] mode;
  logic       sec_en;
  logic       half_en;
  logic       inc_btn;
  logic [4:0] hour;
  logic [5:0] minute;
  logic [5:0] second;
  logic [2:0] blink_mask;
  logic       setting;

  time_set_ctrl #(.HOUR_MAX(HM)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sec_en(sec_en), .half_en(half_en),
    .inc_btn(inc_btn), .hour(hour), .minute(minute), .second(second),
    .blink_mask(blink_mask), .setting(setting)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] md;
    logic       sec;
    logic       half;
    logic       btn;
    int         h;
    int         m;
    int         s;
    logic [2:0] mask;
    logic       set;
  } vec_t;

  typedef struct {
    int         h;
    int         m;
    int         s;
    logic [2:0] mask;
    string      tag;
  } exp_t;

  vec_t  tbl[14];
  exp_t  sb[$];
  int    checks = 0;
  int    errors = 0;
  int    h, m, s;
  string tag;

  task automatic check_outputs(input exp_t e);
    checks++;
    if ({hour, minute, second, blink_mask} !== {5'(e.h), 6'(e.m), 6'(e.s), e.mask}) begin
      errors++;
      $display("FAIL %s: got %0d:%0d:%0d mask %b, want %0d:%0d:%0d mask %b",
               e.tag, hour, minute, second, blink_mask, e.h, e.m, e.s, e.mask);
    end
  endtask

  // Check the previous cycle's result, drive this cycle, queue what the next edge must give
  task automatic cyc(input logic [1:0] md, input logic sec, input logic half,
                     input logic btn, input logic [2:0] mask);
    exp_t e;
    @(negedge clk);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check_outputs(e);
    end
    mode = md; sec_en = sec; half_en = half; inc_btn = btn;
    sb.push_back('{h, m, s, mask, tag});
  endtask

  task automatic flush();
    exp_t e;
    @(negedge clk);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check_outputs(e);
    end
    sec_en = 1'b0; half_en = 1'b0; inc_btn = 1'b0;
  endtask

  task automatic press(input logic [1:0] md);
    case (md)
      2'd1: h = (h == HM) ? 0 : h + 1;
      2'd2: m = (m == 59) ? 0 : m + 1;
      2'd3: s = (s == 59) ? 0 : s + 1;
      default: ;
    endcase
    cyc(md, 1'b0, 1'b0, 1'b1, 3'b000);
    cyc(md, 1'b0, 1'b0, 1'b0, 3'b000);
  endtask

  task automatic tick();
    if (s == 59) begin
      s = 0;
      if (m == 59) begin
        m = 0;
        h = (h == HM) ? 0 : h + 1;
      end else m = m + 1;
    end else s = s + 1;
    cyc(2'd0, 1'b1, 1'b0, 1'b0, 3'b000);
  endtask

  initial begin
    rst_n = 1'b0; mode = 2'd0; sec_en = 1'b0; half_en = 1'b0; inc_btn = 1'b0;
    h = 0; m = 0; s = 0; tag = "reset";
    repeat (2) @(negedge clk);
    checks++;
    if ({hour, minute, second, blink_mask, setting} !== 21'd0) begin
      errors++;
      $display("FAIL reset_state: got %0d:%0d:%0d mask %b set %b, want all zero",
               hour, minute, second, blink_mask, setting);
    end
    rst_n = 1'b1;

    //          md    sec   half  btn   h  m  s  mask    set
    tbl[0]  = '{2'd0, 1'b1, 1'b0, 1'b0, 0, 0, 1, 3'b000, 1'b0};
    tbl[1]  = '{2'd0, 1'b0, 1'b0, 1'b1, 0, 0, 1, 3'b000, 1'b0};
    tbl[2]  = '{2'd0, 1'b1, 1'b0, 1'b1, 0, 0, 2, 3'b000, 1'b0};
    tbl[3]  = '{2'd1, 1'b0, 1'b0, 1'b0, 0, 0, 2, 3'b000, 1'b1};
    tbl[4]  = '{2'd1, 1'b0, 1'b1, 1'b0, 0, 0, 2, 3'b100, 1'b1};
    tbl[5]  = '{2'd1, 1'b0, 1'b0, 1'b1, 1, 0, 2, 3'b000, 1'b1};
    tbl[6]  = '{2'd1, 1'b1, 1'b0, 1'b1, 1, 0, 2, 3'b000, 1'b1};
    tbl[7]  = '{2'd1, 1'b0, 1'b1, 1'b0, 1, 0, 2, 3'b100, 1'b1};
    tbl[8]  = '{2'd2, 1'b0, 1'b0, 1'b1, 1, 1, 2, 3'b000, 1'b1};
    tbl[9]  = '{2'd2, 1'b0, 1'b1, 1'b0, 1, 1, 2, 3'b010, 1'b1};
    tbl[10] = '{2'd3, 1'b0, 1'b0, 1'b1, 1, 1, 3, 3'b000, 1'b1};
    tbl[11] = '{2'd3, 1'b0, 1'b1, 1'b1, 1, 1, 3, 3'b001, 1'b1};
    tbl[12] = '{2'd0, 1'b1, 1'b0, 1'b0, 1, 1, 4, 3'b000, 1'b0};
    tbl[13] = '{2'd0, 1'b0, 1'b1, 1'b0, 1, 1, 4, 3'b000, 1'b0};

    for (int i = 0; i < 14; i++) begin
      h = tbl[i].h; m = tbl[i].m; s = tbl[i].s;
      tag = $sformatf("vec%0d", i);
      cyc(tbl[i].md, tbl[i].sec, tbl[i].half, tbl[i].btn, tbl[i].mask);
      #1;
      checks++;
      if (setting !== tbl[i].set) begin
        errors++;
        $display("FAIL setting_vec%0d: got %b want %b", i, setting, tbl[i].set);
      end
    end
    h = 1; m = 1; s = 4;

    tag = "preload_wrap";
    repeat (22) press(2'd1);
    repeat (58) press(2'd2);
    repeat (55) press(2'd3);
    tag = "full_wrap";
    tick();

    tag = "minute_set";
    repeat (59) press(2'd2);
    tag = "minute_59_wrap";
    press(2'd2);
    tag = "held_press";
    m = m + 1;
    repeat (100) cyc(2'd2, 1'b0, 1'b0, 1'b1, 3'b000);
    cyc(2'd2, 1'b0, 1'b0, 1'b0, 3'b000);

    tag = "freeze";
    repeat (7) press(2'd3);
    cyc(2'd1, 1'b0, 1'b0, 1'b0, 3'b000);
    repeat (5) cyc(2'd1, 1'b1, 1'b0, 1'b0, 3'b000);
    tag = "hour_set";
    repeat (23) press(2'd1);
    tag = "hour_max_wrap";
    press(2'd1);

    tag = "blink";
    cyc(2'd3, 1'b0, 1'b0, 1'b0, 3'b000);
    cyc(2'd3, 1'b0, 1'b1, 1'b0, 3'b001);
    cyc(2'd3, 1'b0, 1'b1, 1'b0, 3'b000);
    cyc(2'd3, 1'b0, 1'b1, 1'b0, 3'b001);
    tag = "blink_press";
    press(2'd3);
    tag = "blink_run";
    cyc(2'd0, 1'b0, 1'b0, 1'b0, 3'b000);
    cyc(2'd0, 1'b0, 1'b1, 1'b0, 3'b000);

    tag = "preload_123456";
    while (h != 12) press(2'd1);
    while (m != 34) press(2'd2);
    while (s != 55) press(2'd3);
    tick();
    cyc(2'd0, 1'b0, 1'b0, 1'b0, 3'b000);
    flush();

    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({hour, minute, second, blink_mask} !== 20'd0) begin
      errors++;
      $display("FAIL async_reset: got %0d:%0d:%0d mask %b, want 0:0:0 mask 000",
               hour, minute, second, blink_mask);
    end
    sec_en = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({hour, minute, second, blink_mask} !== 20'd0) begin
      errors++;
      $display("FAIL reset_hold: got %0d:%0d:%0d mask %b, want 0:0:0 mask 000",
               hour, minute, second, blink_mask);
    end

    sec_en = 1'b0; mode = 2'd1; inc_btn = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    h = 1; m = 0; s = 0; tag = "btn_across_reset";
    sb.push_back('{h, m, s, 3'b000, tag});
    repeat (3) cyc(2'd1, 1'b0, 1'b0, 1'b1, 3'b000);
    cyc(2'd1, 1'b0, 1'b0, 1'b0, 3'b000);
    flush();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
